iter_controller: RTL and testbench
==================================

ITER_CONTROLLER -- requirements
Module: iter_controller

Interface
REQ-001 Parameter: W, 4, counter width; loop runs up to 2^W iterations.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-low reset; rst=0 forces the reset state immediately.
REQ-004 start  input  1  request a loop run; sampled only in IDLE.
REQ-005 init_val  input  W  loop start value, captured on accepted start.
REQ-006 stall  input  1  hold current iteration; no counter enable while 1.
REQ-007 abort  input  1  synchronous cancel of a run in progress.
REQ-008 co  input  1  counter carry-out; high when counter is all-ones and cnt_en=1 (combinational in counter).
REQ-009 cnt_load  output  1  counter parallel-load strobe.
REQ-010 cnt_en  output  1  counter increment enable.
REQ-011 cnt_in  output  W  counter load value.
REQ-012 busy  output  1  high in LOAD and RUN.
REQ-013 done  output  1  one-cycle pulse at normal loop completion.
REQ-014 iter_cnt  output  W+1  number of enables issued in the current/last run.

Function
REQ-015 The block SHALL be a Moore FSM with states IDLE, LOAD, RUN, DONE, all outputs registered or decoded from state plus stall only.
REQ-016 IDLE: start=1 SHALL capture init_val into an internal register and move to LOAD; otherwise stay.
REQ-017 LOAD: cnt_load=1, cnt_in=captured value, cnt_en=0, iter_cnt cleared to 0; next state RUN unconditionally after one cycle.
REQ-018 RUN: cnt_en = ~stall; cnt_load=0; each cycle with cnt_en=1 SHALL increment iter_cnt by 1.
REQ-019 RUN: co SHALL be sampled only when cnt_en=1; co=1 with cnt_en=1 marks the final iteration and moves to DONE next cycle.
REQ-020 co=1 while cnt_en=0 (stall) SHALL be ignored.
REQ-021 DONE: done=1 for exactly one cycle, cnt_en=0, cnt_load=0; next state IDLE; iter_cnt holds its final value until the next LOAD.
REQ-022 Iteration count SHALL equal 2^W - init_val; init_val=0 gives 2^W (iter_cnt=16 for W=4), init_val=2^W-1 gives 1.
REQ-023 cnt_load and cnt_en SHALL never be high in the same cycle.
REQ-024 start outside IDLE (including DONE) SHALL be ignored; no queuing.
REQ-025 abort=1 in LOAD or RUN SHALL force IDLE next cycle with no done pulse; abort has priority over co in the same cycle.
REQ-026 abort in IDLE or DONE SHALL have no effect; DONE still pulses and returns to IDLE.
REQ-027 Counter wrap to 0 after the final enable SHALL not affect the controller (state already leaving RUN).
REQ-028 cnt_in SHALL be stable from LOAD until the next accepted start.

Reset
REQ-029 rst=0 SHALL asynchronously force IDLE, cnt_load=0, cnt_en=0, cnt_in=0, busy=0, done=0, iter_cnt=0, captured value=0.
REQ-030 Reset asserted mid-run SHALL abandon the run with no done pulse; after release the block waits in IDLE for a new start.
REQ-031 First start accepted SHALL be in the first rising edge after rst returns to 1.

Verification
REQ-032 init_val=12, start pulse, no stall -> LOAD 1 cycle with cnt_in=12, cnt_en high 4 cycles, co on 4th, done pulse next cycle, iter_cnt=4.
REQ-033 init_val=0 -> 16 enables, iter_cnt=16, single done pulse; init_val=15 -> 1 enable, iter_cnt=1.
REQ-034 init_val=13 with stall=1 for 3 cycles mid-run and co forced high during stall -> no completion during stall, total enables 3, iter_cnt=3, done once.
REQ-035 abort on same cycle as co in RUN -> IDLE, no done, busy drops next cycle; start during busy -> ignored, no second run.
REQ-036 rst pulled low mid-RUN (between clock edges) -> all outputs 0 immediately, no done; new start after release runs normally.
REQ-037 Every cycle of every test: cnt_load & cnt_en = 0, done high at most one consecutive cycle.

Source files
------------

// File: rtl/iter_controller.sv
// iter_controller: sequences an external W-bit up-counter through one loop run.
// A run loads the counter with a captured start value, then enables it until the
// counter reports carry-out, giving 2^W - init_val iterations. A run may be
// cancelled with abort, or abandoned by reset.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   start     run request, honoured only in IDLE
//   init_val  loop start value, captured on an accepted start
//   stall     holds the current iteration (no counter enable)
//   abort     cancels a run in LOAD or RUN
//   co        counter carry-out (all-ones while enabled)
//   cnt_load  counter parallel-load strobe
//   cnt_en    counter increment enable
//   cnt_in    counter load value
//   busy      high in LOAD and RUN
//   done      one-cycle pulse at normal completion
//   iter_cnt  enables issued in the current/last run
module iter_controller #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] init_val,
   input  logic         stall,
   input  logic         abort,
   input  logic         co,
   output logic         cnt_load,
   output logic         cnt_en,
   output logic [W-1:0] cnt_in,
   output logic         busy,
   output logic         done,
   output logic [W:0]   iter_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t       state;
   state_t       state_nxt;
   logic [W-1:0] cap;
   logic [W:0]   iter;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Captured start value and iteration count; the count restarts with each
   // accepted start so it already reads zero during LOAD.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap  <= '0;
         iter <= '0;
      end else if (state == IDLE && start) begin
         cap  <= init_val;
         iter <= '0;
      end else if (cnt_en) begin
         iter <= iter + (W+1)'(1);
      end
   end

   // Next state and Moore outputs (decoded from state, plus stall in RUN).
   // co only counts while enabled; abort outranks co.
   always_comb begin
      state_nxt = state;
      cnt_load  = 1'b0;
      cnt_en    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_nxt = LOAD;
         end
         LOAD: begin
            cnt_load  = 1'b1;
            busy      = 1'b1;
            state_nxt = abort ? IDLE : RUN;
         end
         RUN: begin
            cnt_en = ~stall;
            busy   = 1'b1;
            if (abort)            state_nxt = IDLE;
            else if (!stall && co) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign cnt_in   = cap;
   assign iter_cnt = iter;

endmodule

// File: tb/tb_iter_controller.sv
// Bench for iter_controller: an external 4-bit counter model drives co, a
// run-level reference model (remaining-iteration budget) predicts every output,
// and directed scenarios add literal expectations.
module tb_iter_controller;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] init_val = '0;
   logic         stall = 1'b0;
   logic         abort = 1'b0;
   logic         co;
   logic         force_co = 1'b0;
   logic         cnt_load, cnt_en, busy, done;
   logic [W-1:0] cnt_in;
   logic [W:0]   iter_cnt;

   int total = 0;
   int passed = 0;
   int en_cnt = 0;
   int done_cnt = 0;
   bit chk_on = 1'b0;
   logic prev_done = 1'b0;

   iter_controller #(.W(W)) dut (
      .clk(clk), .rst(rst), .start(start), .init_val(init_val),
      .stall(stall), .abort(abort), .co(co),
      .cnt_load(cnt_load), .cnt_en(cnt_en), .cnt_in(cnt_in),
      .busy(busy), .done(done), .iter_cnt(iter_cnt)
   );

   always #5 clk = ~clk;

   // External counter the controller drives
   logic [W-1:0] ctr = '0;
   always @(posedge clk) begin
      if (cnt_load)    ctr <= cnt_in;
      else if (cnt_en) ctr <= ctr + 4'd1;
   end
   assign co = (cnt_en && ctr == 4'hF) || force_co;

   // Reference model: a run is a load cycle, then enables on every unstalled
   // cycle until 2^W - init_val of them have been issued, then one done cycle.
   bit         m_load = 0, m_run = 0, m_done = 0;
   int         m_remain = 0;
   int         m_iter = 0;
   logic [3:0] m_cap = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_load <= 0; m_run <= 0; m_done <= 0;
         m_remain <= 0; m_iter <= 0; m_cap <= '0;
      end else begin
         if (m_done) begin
            m_done <= 0;
         end else if (m_load) begin
            m_load <= 0;
            m_run  <= !abort;
         end else if (m_run) begin
            if (!stall) begin
               m_iter   <= m_iter + 1;
               m_remain <= m_remain - 1;
            end
            if (abort) begin
               m_run <= 0;
            end else if (!stall && m_remain == 1) begin
               m_run  <= 0;
               m_done <= 1;
            end
         end else if (start) begin
            m_load   <= 1;
            m_cap    <= init_val;
            m_iter   <= 0;
            m_remain <= 16 - int'(init_val);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Per-cycle comparison against the model plus invariants
   always @(negedge clk) begin
      if (chk_on) begin
         chk("cnt_load", int'(cnt_load), int'(m_load));
         chk("cnt_en", int'(cnt_en), int'(m_run && !stall));
         chk("busy", int'(busy), int'(m_load || m_run));
         chk("done", int'(done), int'(m_done));
         chk("cnt_in", int'(cnt_in), int'(m_cap));
         chk("iter_cnt", int'(iter_cnt), m_iter);
         chk("load_en_excl", int'(cnt_load & cnt_en), 0);
         chk("done_single", int'(done & prev_done), 0);
         if (cnt_en) en_cnt++;
         if (done) done_cnt++;
      end
      prev_done <= done;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_counts();
      en_cnt = 0;
      done_cnt = 0;
   endtask

   // Waits until the run has finished (idle, not in the done cycle)
   task automatic wait_idle(input int budget);
      bit ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy && !done) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("wait_idle_timeout", 0, 1);
      #1;
   endtask

   task automatic run(input logic [3:0] v, input int budget);
      clr_counts();
      init_val = v;
      start = 1'b1;
      cyc();
      start = 1'b0;
      wait_idle(budget);
   endtask

   initial begin
      #1 rst = 1'b0;
      #20;
      chk("rst_busy", int'(busy), 0);
      chk("rst_iter", int'(iter_cnt), 0);
      chk("rst_cnt_in", int'(cnt_in), 0);
      @(negedge clk);
      rst = 1'b1;
      chk_on = 1'b1;
      cyc();

      // init 12: one load cycle with cnt_in=12, then 4 enables
      clr_counts();
      init_val = 4'd12;
      start = 1'b1;
      cyc();
      start = 1'b0;
      @(negedge clk);
      chk("t1_load", int'(cnt_load), 1);
      chk("t1_cnt_in", int'(cnt_in), 12);
      chk("t1_iter0", int'(iter_cnt), 0);
      wait_idle(40);
      chk("t1_iter", int'(iter_cnt), 4);
      chk("t1_en", en_cnt, 4);
      chk("t1_done", done_cnt, 1);

      // boundaries: full 16 iterations and a single iteration
      run(4'd0, 60);
      chk("t2_iter", int'(iter_cnt), 16);
      chk("t2_en", en_cnt, 16);
      chk("t2_done", done_cnt, 1);
      run(4'd15, 20);
      chk("t3_iter", int'(iter_cnt), 1);
      chk("t3_done", done_cnt, 1);

      // init 13, stall 3 cycles with co forced high during the stall
      clr_counts();
      init_val = 4'd13;
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      stall = 1'b1;
      force_co = 1'b1;
      repeat (3) cyc();
      stall = 1'b0;
      force_co = 1'b0;
      wait_idle(30);
      chk("t4_iter", int'(iter_cnt), 3);
      chk("t4_en", en_cnt, 3);
      chk("t4_done", done_cnt, 1);

      // abort in the same cycle as co
      clr_counts();
      init_val = 4'd14;
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      @(negedge clk);
      chk("t5_busy", int'(busy), 0);
      chk("t5_done", done_cnt, 0);
      chk("t5_iter", int'(iter_cnt), 2);
      #1;

      // start during busy and during DONE is ignored
      clr_counts();
      init_val = 4'd12;
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      init_val = 4'd3;
      start = 1'b1;
      cyc();
      cyc();
      start = 1'b0;
      begin
         bit seen = 0;
         for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
               seen = 1;
               break;
            end
         end
         if (!seen) chk("t6_done_timeout", 0, 1);
      end
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) cyc();
      chk("t6_busy", int'(busy), 0);
      chk("t6_done", done_cnt, 1);
      chk("t6_iter", int'(iter_cnt), 4);
      chk("t6_cnt_in", int'(cnt_in), 12);

      // reset mid-run, then start on the first edge after release
      clr_counts();
      init_val = 4'd8;
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      #2 rst = 1'b0;
      #1;
      chk("t7_rst_en", int'(cnt_en), 0);
      chk("t7_rst_busy", int'(busy), 0);
      chk("t7_rst_iter", int'(iter_cnt), 0);
      chk("t7_rst_cnt_in", int'(cnt_in), 0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      init_val = 4'd10;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("t7_load", int'(cnt_load), 1);
      chk("t7_cnt_in", int'(cnt_in), 10);
      wait_idle(30);
      chk("t7_iter", int'(iter_cnt), 6);
      chk("t7_done", done_cnt, 1);

      cyc();
      chk_on = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
